// File: rtl/ddr_chan_sched.sv
// Shares the single DDR port between pc burst fetch, LSU store and LSU load.
// Grants one requester at a time, strobes one command, and returns its completion.
module ddr_chan_sched #(
  parameter int IDX_W        = 19,
  parameter int STARVE_LIMIT = 8,
  parameter int TIMEOUT      = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pc_index_valid,
  input  logic [IDX_W-1:0] pc_index,
  input  logic             pc_flush,
  output logic             pc_index_ready,
  output logic [511:0]     pc_read_inst,
  output logic             pc_operation_done,
  input  logic             opstore_index_valid,
  input  logic [IDX_W-1:0] opstore_index,
  input  logic [63:0]      opstore_write_mask,
  input  logic [63:0]      opstore_write_data,
  output logic             opstore_index_ready,
  output logic             opstore_operation_done,
  input  logic             opload_index_valid,
  input  logic [IDX_W-1:0] opload_index,
  output logic             opload_index_ready,
  output logic [63:0]      opload_read_data,
  output logic             opload_operation_done,
  output logic             ddr_chip_enable,
  output logic [IDX_W-1:0] ddr_index,
  output logic             ddr_write_enable,
  output logic             ddr_burst_mode,
  output logic [63:0]      ddr_opstore_write_mask,
  output logic [63:0]      ddr_opstore_write_data,
  input  logic [63:0]      ddr_opload_read_data,
  input  logic [511:0]     ddr_pc_read_inst,
  input  logic             ddr_operation_done,
  input  logic             ddr_ready,
  output logic             sched_busy,
  output logic             err_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] GID_STORE = 2'd0;
  localparam logic [1:0] GID_LOAD  = 2'd1;
  localparam logic [1:0] GID_PC    = 2'd2;

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [1:0]         gid_q, gid_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [63:0]        mask_q, mask_d;
  logic [63:0]        data_q, data_d;
  logic               we_q, we_d;
  logic               burst_q, burst_d;
  logic [SC_W-1:0]    starve_q, starve_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               flush_q, flush_d;
  logic               err_q, err_d;
  logic [511:0]       pc_inst_q, pc_inst_d;
  logic [63:0]        ld_data_q, ld_data_d;
  logic               do_cap, do_to;

  always_comb begin
    state_d             = state_q;
    gid_d               = gid_q;
    index_d             = index_q;
    mask_d              = mask_q;
    data_d              = data_q;
    we_d                = we_q;
    burst_d             = burst_q;
    starve_d            = starve_q;
    wd_d                = wd_q;
    flush_d             = flush_q;
    err_d               = err_q;
    pc_inst_d           = pc_inst_q;
    ld_data_d           = ld_data_q;
    pc_index_ready      = 1'b0;
    opstore_index_ready = 1'b0;
    opload_index_ready  = 1'b0;
    do_cap              = 1'b0;
    do_to               = 1'b0;

    case (state_q)
      IDLE: begin
        // A starved pc jumps ahead of the normal store > load > pc order.
        if (ddr_ready) begin
          if (pc_index_valid && starve_q == STARVE_MAX) pc_index_ready = 1'b1;
          else if (opstore_index_valid)                 opstore_index_ready = 1'b1;
          else if (opload_index_valid)                  opload_index_ready = 1'b1;
          else if (pc_index_valid)                      pc_index_ready = 1'b1;
        end
        if (opstore_index_ready) begin
          gid_d   = GID_STORE;
          index_d = opstore_index;
          mask_d  = opstore_write_mask;
          data_d  = opstore_write_data;
          we_d    = 1'b1;
          burst_d = 1'b0;
          state_d = ISSUE;
        end else if (opload_index_ready) begin
          gid_d   = GID_LOAD;
          index_d = opload_index;
          we_d    = 1'b0;
          burst_d = 1'b0;
          state_d = ISSUE;
        end else if (pc_index_ready) begin
          gid_d   = GID_PC;
          index_d = pc_index;
          we_d    = 1'b0;
          burst_d = 1'b1;
          flush_d = pc_flush;
          state_d = ISSUE;
        end
        if (pc_index_ready)
          starve_d = '0;
        else if (pc_index_valid && starve_q != STARVE_MAX)
          starve_d = starve_q + 1'b1;
      end
      ISSUE: begin
        flush_d = flush_q | (pc_flush && gid_q == GID_PC);
        do_cap  = ddr_operation_done;
        state_d = ddr_operation_done ? RESP : WAIT;
      end
      WAIT: begin
        flush_d = flush_q | (pc_flush && gid_q == GID_PC);
        wd_d    = wd_q + 1'b1;
        if (ddr_operation_done) begin
          do_cap  = 1'b1;
          state_d = RESP;
        end else if (wd_q == WD_LAST) begin
          do_to   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        wd_d    = '0;
        flush_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // A watchdog expiry still completes the operation, but with zeroed data.
    if (do_to) err_d = 1'b1;
    if ((do_cap || do_to) && gid_q == GID_LOAD)
      ld_data_d = do_to ? 64'd0 : ddr_opload_read_data;
    if ((do_cap || do_to) && gid_q == GID_PC && !flush_d)
      pc_inst_d = do_to ? 512'd0 : ddr_pc_read_inst;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      gid_q     <= '0;
      index_q   <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      burst_q   <= 1'b0;
      starve_q  <= '0;
      wd_q      <= '0;
      flush_q   <= 1'b0;
      err_q     <= 1'b0;
      pc_inst_q <= '0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      gid_q     <= gid_d;
      index_q   <= index_d;
      mask_q    <= mask_d;
      data_q    <= data_d;
      we_q      <= we_d;
      burst_q   <= burst_d;
      starve_q  <= starve_d;
      wd_q      <= wd_d;
      flush_q   <= flush_d;
      err_q     <= err_d;
      pc_inst_q <= pc_inst_d;
      ld_data_q <= ld_data_d;
    end
  end

  assign pc_operation_done      = (state_q == RESP) && (gid_q == GID_PC) && !flush_q;
  assign opstore_operation_done = (state_q == RESP) && (gid_q == GID_STORE);
  assign opload_operation_done  = (state_q == RESP) && (gid_q == GID_LOAD);
  assign ddr_chip_enable        = (state_q == ISSUE);
  assign sched_busy             = (state_q != IDLE);
  assign ddr_index              = index_q;
  assign ddr_write_enable       = we_q;
  assign ddr_burst_mode         = burst_q;
  assign ddr_opstore_write_mask = mask_q;
  assign ddr_opstore_write_data = data_q;
  assign pc_read_inst           = pc_inst_q;
  assign opload_read_data       = ld_data_q;
  assign err_timeout            = err_q;

endmodule

// File: tb/tb_ddr_chan_sched.sv
// Self-checking bench for ddr_chan_sched: directed scenarios plus randomized
// operations, checked against a transaction-level model of the arbitration rules.
module tb_ddr_chan_sched;

  localparam int IDX_W   = 19;
  localparam int SLIMIT  = 8;
  localparam int TMO     = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             pc_index_valid;
  logic [IDX_W-1:0] pc_index;
  logic             pc_flush;
  logic             pc_index_ready;
  logic [511:0]     pc_read_inst;
  logic             pc_operation_done;
  logic             opstore_index_valid;
  logic [IDX_W-1:0] opstore_index;
  logic [63:0]      opstore_write_mask;
  logic [63:0]      opstore_write_data;
  logic             opstore_index_ready;
  logic             opstore_operation_done;
  logic             opload_index_valid;
  logic [IDX_W-1:0] opload_index;
  logic             opload_index_ready;
  logic [63:0]      opload_read_data;
  logic             opload_operation_done;
  logic             ddr_chip_enable;
  logic [IDX_W-1:0] ddr_index;
  logic             ddr_write_enable;
  logic             ddr_burst_mode;
  logic [63:0]      ddr_opstore_write_mask;
  logic [63:0]      ddr_opstore_write_data;
  logic [63:0]      ddr_opload_read_data;
  logic [511:0]     ddr_pc_read_inst;
  logic             ddr_operation_done;
  logic             ddr_ready;
  logic             sched_busy;
  logic             err_timeout;

  int checks = 0;
  int errors = 0;

  int           starveM;
  logic [63:0]  expLoad;
  logic [511:0] expPc;
  logic         expErr;

  ddr_chan_sched #(.IDX_W(IDX_W), .STARVE_LIMIT(SLIMIT), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .pc_index_valid(pc_index_valid), .pc_index(pc_index), .pc_flush(pc_flush),
    .pc_index_ready(pc_index_ready), .pc_read_inst(pc_read_inst),
    .pc_operation_done(pc_operation_done),
    .opstore_index_valid(opstore_index_valid), .opstore_index(opstore_index),
    .opstore_write_mask(opstore_write_mask), .opstore_write_data(opstore_write_data),
    .opstore_index_ready(opstore_index_ready), .opstore_operation_done(opstore_operation_done),
    .opload_index_valid(opload_index_valid), .opload_index(opload_index),
    .opload_index_ready(opload_index_ready), .opload_read_data(opload_read_data),
    .opload_operation_done(opload_operation_done),
    .ddr_chip_enable(ddr_chip_enable), .ddr_index(ddr_index),
    .ddr_write_enable(ddr_write_enable), .ddr_burst_mode(ddr_burst_mode),
    .ddr_opstore_write_mask(ddr_opstore_write_mask),
    .ddr_opstore_write_data(ddr_opstore_write_data),
    .ddr_opload_read_data(ddr_opload_read_data), .ddr_pc_read_inst(ddr_pc_read_inst),
    .ddr_operation_done(ddr_operation_done), .ddr_ready(ddr_ready),
    .sched_busy(sched_busy), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Winner: 0 store, 1 load, 2 pc, -1 nobody.
  function automatic int pickWinner(bit sv, bit lv, bit pv, int st);
    if (pv && st == SLIMIT) return 2;
    if (sv) return 0;
    if (lv) return 1;
    if (pv) return 2;
    return -1;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ready"}, {pc_index_ready, opstore_index_ready, opload_index_ready}, 3'b000);
    checkOutput({tag, "_done"}, {pc_operation_done, opstore_operation_done, opload_operation_done}, 3'b000);
    checkOutput({tag, "_ctrl"}, {ddr_chip_enable, ddr_write_enable, ddr_burst_mode, sched_busy, err_timeout}, 5'b0);
    checkOutput({tag, "_index"}, ddr_index, '0);
    checkOutput({tag, "_mask"}, ddr_opstore_write_mask, '0);
    checkOutput({tag, "_wdata"}, ddr_opstore_write_data, '0);
    checkOutput({tag, "_ldata"}, opload_read_data, '0);
    checkOutput({tag, "_pcinst"}, pc_read_inst, '0);
  endtask

  // One complete operation. delay<0 means DDR never completes; flushOff is the
  // cycle (0 = grant cycle) in which pc_flush pulses, or -1 for none.
  task automatic applyStimulus(input bit sv, input bit lv, input bit pv,
                               input logic [IDX_W-1:0] sIdx, input logic [IDX_W-1:0] lIdx,
                               input logic [IDX_W-1:0] pIdx,
                               input logic [63:0] mask, input logic [63:0] wdata,
                               input int delay, input int flushOff, input int notReady,
                               input logic [63:0] ldData, input logic [511:0] pcData);
    int win, doneOff, respOff;
    bit flushed, timedOut;
    logic [2:0] expRdy;
    logic [IDX_W-1:0] expIdx;

    for (int k = 0; k < notReady; k++) begin
      @(posedge clock); #1;
      opstore_index_valid = sv; opload_index_valid = lv; pc_index_valid = pv;
      opstore_index = sIdx; opload_index = lIdx; pc_index = pIdx;
      opstore_write_mask = mask; opstore_write_data = wdata;
      ddr_ready = 1'b0; pc_flush = 1'b0;
      ddr_operation_done = 1'($urandom_range(0, 1));
      @(negedge clock);
      checkOutput("noready_rdy", {opstore_index_ready, opload_index_ready, pc_index_ready}, 3'b000);
      checkOutput("noready_busy", sched_busy, 1'b0);
      if (pv && starveM < SLIMIT) starveM++;
    end

    win      = pickWinner(sv, lv, pv, starveM);
    expRdy   = (win == 0) ? 3'b100 : (win == 1) ? 3'b010 : 3'b001;
    expIdx   = (win == 0) ? sIdx : (win == 1) ? lIdx : pIdx;
    timedOut = (delay < 0);
    doneOff  = timedOut ? 1 + TMO : 1 + delay;
    respOff  = doneOff + 1;
    flushed  = (win == 2) && (flushOff >= 0) && (flushOff <= doneOff);
    if (win == 2) starveM = 0;
    else if (pv && starveM < SLIMIT) starveM++;

    for (int c = 0; c <= respOff; c++) begin
      @(posedge clock); #1;
      if (c == 0) begin
        opstore_index_valid = sv; opload_index_valid = lv; pc_index_valid = pv;
        opstore_index = sIdx; opload_index = lIdx; pc_index = pIdx;
        opstore_write_mask = mask; opstore_write_data = wdata;
        ddr_ready = 1'b1;
      end else begin
        opstore_index_valid = 1'b0; opload_index_valid = 1'b0; pc_index_valid = 1'b0;
      end
      if (c == respOff) ddr_operation_done = 1'($urandom_range(0, 1));
      else ddr_operation_done = (!timedOut && c == doneOff);
      ddr_opload_read_data = (c == doneOff) ? ldData : rand64();
      ddr_pc_read_inst     = (c == doneOff) ? pcData : rand512();
      pc_flush = (c == flushOff);
      @(negedge clock);
      if (c == 0)
        checkOutput("grant_ready", {opstore_index_ready, opload_index_ready, pc_index_ready}, expRdy);
      checkOutput("busy", sched_busy, (c != 0));
      checkOutput("chip_enable", ddr_chip_enable, (c == 1));
      if (c >= 1 && c <= doneOff) begin
        checkOutput("ddr_index", ddr_index, expIdx);
        checkOutput("ddr_we_burst", {ddr_write_enable, ddr_burst_mode}, {win == 0, win == 2});
        if (win == 0)
          checkOutput("ddr_mask_data", {ddr_opstore_write_mask, ddr_opstore_write_data}, {mask, wdata});
      end
      checkOutput("done_pulses", {opstore_operation_done, opload_operation_done, pc_operation_done},
                  (c == respOff && !flushed) ? expRdy : 3'b000);
    end

    if (win == 1) expLoad = timedOut ? 64'd0 : ldData;
    if (win == 2 && !flushed) expPc = timedOut ? 512'd0 : pcData;
    if (timedOut) expErr = 1'b1;
    checkOutput("load_data", opload_read_data, expLoad);
    checkOutput("pc_inst", pc_read_inst, expPc);
    checkOutput("err_timeout", err_timeout, expErr);
  endtask

  task automatic resetModel();
    starveM = 0;
    expLoad = '0;
    expPc   = '0;
    expErr  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    pc_index_valid = 0; pc_index = '0; pc_flush = 0;
    opstore_index_valid = 0; opstore_index = '0; opstore_write_mask = '0; opstore_write_data = '0;
    opload_index_valid = 0; opload_index = '0;
    ddr_opload_read_data = '0; ddr_pc_read_inst = '0; ddr_operation_done = 0; ddr_ready = 1;
    resetModel();
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkAllZero("reset");
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);

    $display("[TB] store only");
    applyStimulus(1, 0, 0, 19'h01234, 19'h0, 19'h0, 64'hFF, 64'hDEAD, 3, -1, 0, 64'h0, 512'h0);

    $display("[TB] store, load and pc together");
    applyStimulus(1, 1, 1, 19'h00100, 19'h00200, 19'h00300, 64'h0F, 64'h1111, 2, -1, 0, 64'h0, 512'h0);
    applyStimulus(0, 1, 1, 19'h0, 19'h00200, 19'h00300, 64'h0, 64'h0, 2, -1, 0, 64'hCAFE, 512'h0);
    applyStimulus(0, 0, 1, 19'h0, 19'h0, 19'h00300, 64'h0, 64'h0, 2, -1, 0, 64'h0, rand512());

    $display("[TB] pc starvation");
    for (int i = 0; i < SLIMIT + 2; i++)
      applyStimulus((i % 2) == 0, (i % 2) == 1, 1, 19'($urandom), 19'($urandom), 19'($urandom),
                    rand64(), rand64(), $urandom_range(0, 3), -1, 0, rand64(), rand512());

    $display("[TB] flush");
    applyStimulus(0, 0, 1, 19'h0, 19'h0, 19'h00777, 64'h0, 64'h0, 4, 3, 0, 64'h0, rand512());
    applyStimulus(1, 0, 0, 19'h00555, 19'h0, 19'h0, rand64(), rand64(), 2, 1, 0, 64'h0, rand512());

    $display("[TB] watchdog");
    applyStimulus(0, 1, 0, 19'h0, 19'h00ABC, 19'h0, 64'h0, 64'h0, -1, -1, 0, rand64(), rand512());

    $display("[TB] random operations");
    for (int i = 0; i < 40; i++) begin
      bit sv, lv, pv;
      int dly, fo;
      {sv, lv, pv} = 3'($urandom_range(1, 7));
      dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
      fo  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
      applyStimulus(sv, lv, pv, 19'($urandom), 19'($urandom), 19'($urandom), rand64(), rand64(),
                    dly, fo, $urandom_range(0, 2), rand64(), rand512());
    end

    $display("[TB] reset during pc burst");
    @(posedge clock); #1;
    pc_index_valid = 1; pc_index = 19'h04242; ddr_ready = 1; ddr_operation_done = 0; pc_flush = 0;
    @(negedge clock);
    checkOutput("rst_pc_grant", pc_index_ready, 1'b1);
    @(posedge clock); #1 pc_index_valid = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_in_wait", {sched_busy, ddr_burst_mode}, 2'b11);
    #1 reset = 1'b1;
    #1 checkAllZero("mid_reset");
    resetModel();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    applyStimulus(0, 1, 0, 19'h0, 19'h00321, 19'h0, 64'h0, 64'h0, 1, -1, 0, rand64(), rand512());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_chan_sched.md
Name: ddr_chan_sched

Overview:
- Registered scheduler that shares the single DDR port between three requesters: the pc burst-fetch channel, the LSU store channel and the LSU load channel.
- It grants one request at a time and latches its command. It issues exactly one chip-enable pulse, tracks the outstanding operation to completion and returns the response to the granted channel only.
- It adds pc anti-starvation, fetch-flush on redirect, and a watchdog timeout.

Parameters:
- IDX_W, 19, DDR index width.
- STARVE_LIMIT, 8, cycles a pending pc request may lose arbitration before it is forced to win.
- TIMEOUT, 1024, maximum cycles spent in WAIT before the watchdog fires.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_index_valid  in  1  fetch request.
- pc_index  in  IDX_W  fetch index.
- pc_flush  in  1  redirect; drop any in-flight fetch response.
- pc_index_ready  out  1  grant/accept pulse.
- pc_read_inst  out  512  registered burst data.
- pc_operation_done  out  1  completion pulse.
- opstore_index_valid  in  1  store request.
- opstore_index  in  IDX_W  store index.
- opstore_write_mask  in  64  store write mask.
- opstore_write_data  in  64  store write data.
- opstore_index_ready  out  1  accept pulse.
- opstore_operation_done  out  1  completion pulse.
- opload_index_valid  in  1  load request.
- opload_index  in  IDX_W  load index.
- opload_index_ready  out  1  accept pulse.
- opload_read_data  out  64  registered load data.
- opload_operation_done  out  1  completion pulse.
- ddr_chip_enable  out  1  one-cycle command strobe.
- ddr_index  out  IDX_W  latched index.
- ddr_write_enable  out  1  1 only for store.
- ddr_burst_mode  out  1  1 only for pc.
- ddr_opstore_write_mask  out  64  latched mask.
- ddr_opstore_write_data  out  64  latched data.
- ddr_opload_read_data  in  64  DDR load data.
- ddr_pc_read_inst  in  512  DDR burst data.
- ddr_operation_done  in  1  DDR completion.
- ddr_ready  in  1  DDR idle.
- sched_busy  out  1  state != IDLE.
- err_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, active-high): state=IDLE, every output 0 including all data and latch registers, starve_cnt=0, wd_cnt=0, flush_lat=0, err_timeout=0.
- State IDLE:
  - A grant happens only if ddr_ready=1 and at least one valid is high.
  - Priority is store > load > pc. If starve_cnt==STARVE_LIMIT, pc takes top priority.
  - In the grant cycle the winner's *_index_ready=1 combinationally (accept = valid&ready). Losers see ready=0.
  - Latched on grant: index; mask and data for store only; grant id. Next state is ISSUE.
  - starve_cnt increments (saturating at STARVE_LIMIT) each IDLE cycle in which pc is valid and not granted. It clears when pc is granted.
  - With ddr_ready=0, no ready is asserted and the state stays IDLE.
- State ISSUE:
  - ddr_chip_enable=1 for exactly this one cycle. ddr_index, write_enable and burst_mode come from the latches and stay stable through WAIT.
  - Next state is WAIT. If ddr_operation_done is already 1 in this cycle, it is captured and the next state is RESP.
- State WAIT:
  - wd_cnt increments each cycle.
  - On ddr_operation_done: capture ddr_opload_read_data (load) or ddr_pc_read_inst (pc) into the output register, then go to RESP.
  - If wd_cnt reaches TIMEOUT-1 without done: set err_timeout, clear the captured data to 0, go to RESP.
- State RESP:
  - Exactly one *_operation_done pulse, on the granted channel only. Next state is IDLE; wd_cnt and flush_lat clear.
  - Read data registers hold their value until the next capture on that channel.
- Flush:
  - pc_flush=1 in any cycle from the pc grant cycle through WAIT sets flush_lat.
  - In RESP with flush_lat=1, pc_operation_done is suppressed and pc_read_inst is not updated.
  - The DDR operation itself still completes; it is never aborted.
  - pc_flush has no effect on store/load grants or in IDLE without a pc grant.
- ddr_operation_done seen in IDLE or RESP is ignored.
- Latency: grant at T, chip_enable at T+1, DDR done at D, channel done at D+1. The next grant is no earlier than D+2. At most one operation is outstanding.
- Reset asserted mid-operation returns to IDLE immediately. No done pulse is emitted for the lost operation.

Test Plan:
- Store only, index 0x1234, mask 0xFF, data 0xDEAD, DDR done 3 cycles after chip_enable -> opstore_index_ready at T; chip_enable at T+1 with write_enable=1, burst=0; opstore_operation_done at T+5; no other done pulses.
- Store, load and pc all valid together, DDR responds in 2 cycles -> grants in order store, load, pc. Each chip_enable is a single cycle. opload_read_data equals the DDR value 0xCAFE after the load's done pulse.
- pc held valid while alternating store/load requests arrive every IDLE cycle -> pc forced to win after 8 lost IDLE cycles; starve_cnt returns to 0.
- pc granted, pc_flush pulsed 1 cycle during WAIT -> DDR burst completes, pc_operation_done never pulses, pc_read_inst is unchanged.
- Load granted, DDR never asserts done, TIMEOUT=16 -> err_timeout=1 sticky, opload_operation_done pulses once with data 0, return to IDLE.
- Reset asserted during WAIT of a pc burst -> all outputs 0 immediately. After release with a new load, the done pulse goes to load only.
